// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared MD operation codes and MD-class decode helper
package md_unit_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

    // True for ops that run multi-cycle and load the pending HI/LO pair.
    function automatic logic md_is_long(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // MD-class flag for the hazard controller; mfhi/mflo are decoded outside
    // this unit, so the decoder ORs their flags with this one.
    function automatic logic md_is_class(input logic [MD_OP_W-1:0] op);
        return md_is_long(op) || (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational multiply/divide arithmetic for md_unit
// Ports:
//   md_op  : operation code (md_unit_pkg constants)
//   A, B   : rs / rt operands
//   hi_res : HI result (product high word or remainder)
//   lo_res : LO result (product low word or quotient)
//   div0   : divide op with B == 0; HI/LO must not be written
module md_calc
    import md_unit_pkg::*;
(
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        A,
    input  logic [31:0]        B,
    output logic [31:0]        hi_res,
    output logic [31:0]        lo_res,
    output logic               div0
);

    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic               w_b_zero;
    logic               w_ovf;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;

    assign w_sprod  = $signed(A) * $signed(B);
    assign w_uprod  = {32'd0, A} * {32'd0, B};
    assign w_b_zero = (B == 32'd0);
    // Most-negative / -1 overflows a signed divide; its result is pinned.
    assign w_ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // Guarded so no divide-by-zero or overflow case reaches the operators.
    assign w_sq = (w_b_zero || w_ovf) ? 32'sd0 : $signed(A) / $signed(B);
    assign w_sr = (w_b_zero || w_ovf) ? 32'sd0 : $signed(A) % $signed(B);
    assign w_uq = w_b_zero ? 32'd0 : A / B;
    assign w_ur = w_b_zero ? 32'd0 : A % B;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        div0   = 1'b0;
        case (md_op)
            MD_MULT:  begin hi_res = w_sprod[63:32]; lo_res = w_sprod[31:0]; end
            MD_MULTU: begin hi_res = w_uprod[63:32]; lo_res = w_uprod[31:0]; end
            MD_DIV: begin
                div0 = w_b_zero;
                if (w_ovf) begin
                    hi_res = 32'd0;
                    lo_res = 32'h8000_0000;
                end else begin
                    hi_res = w_sr;
                    lo_res = w_sq;
                end
            end
            MD_DIVU:  begin div0 = w_b_zero; hi_res = w_ur; lo_res = w_uq; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning HI/LO
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   start        : E-stage MD op, sampled at rising edge
//   md_op        : operation code (md_unit_pkg constants)
//   A, B         : forwarded rs / rt operands
//   req          : E-stage flush, suppresses start this cycle
//   busy         : operation in flight
//   HI, LO       : registered HI / LO
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        A,
    input  logic [31:0]        B,
    input  logic               req,
    output logic               busy,
    output logic [31:0]        HI,
    output logic [31:0]        LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // The counter is the state: zero is IDLE, nonzero is BUSY.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_wr;

    logic [0:0]       w_state;
    logic             w_acc;
    logic [31:0]      w_hi_res;
    logic [31:0]      w_lo_res;
    logic             w_div0;
    logic             w_is_mul;

    md_calc u_calc (
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .hi_res (w_hi_res),
        .lo_res (w_lo_res),
        .div0   (w_div0)
    );

    assign w_state  = (r_cnt != '0) ? ST_BUSY : ST_IDLE;
    assign busy     = (w_state == ST_BUSY);
    assign w_acc    = start && !busy && !req;
    assign w_is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign HI       = r_hi;
    assign LO       = r_lo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (w_state == ST_IDLE) begin
            if (w_acc) begin
                if (md_is_long(md_op)) begin
                    r_pend_hi <= w_hi_res;
                    r_pend_lo <= w_lo_res;
                    // Divide by zero still burns its cycles but commits nothing.
                    r_pend_wr <= !w_div0;
                    r_cnt     <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end else if (md_op == MD_MTHI) begin
                    r_hi <= A;
                end else if (md_op == MD_MTLO) begin
                    r_lo <= A;
                end
            end
        end else if (r_cnt == CNT_W'(1)) begin
            if (r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking scoreboard bench for md_unit
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        req = 1'b0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .A       (A),
        .B       (B),
        .req     (req),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo, input string nm);
        exp_t e;
        e.hi = hi; e.lo = lo; e.nm = nm;
        sb.push_back(e);
    endtask

    // Counts busy cycles at negedges until busy falls, then checks HI/LO
    // against the oldest scoreboard entry.
    task automatic wait_done(input int seen, input int exp_n);
        int   n;
        logic done;
        exp_t e;
        n = seen; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
            else begin
                n++;
                if (n > 200) done = 1'b1;
            end
        end
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (n !== exp_n) begin
                n_bad++;
                $display("FAIL %s_busy_cycles: got %0d required %0d", e.nm, n, exp_n);
            end
            n_cmp++;
            if (HI !== e.hi) begin
                n_bad++;
                $display("FAIL %s_hi: got %h required %h", e.nm, HI, e.hi);
            end
            n_cmp++;
            if (LO !== e.lo) begin
                n_bad++;
                $display("FAIL %s_lo: got %h required %h", e.nm, LO, e.lo);
            end
        end
    endtask

    task automatic check_hilo(input logic [31:0] hi, input logic [31:0] lo,
                              input logic bsy, input string nm);
        n_cmp++;
        if (busy !== bsy) begin n_bad++; $display("FAIL %s_busy: got %b required %b", nm, busy, bsy); end
        n_cmp++;
        if (HI !== hi) begin n_bad++; $display("FAIL %s_hi: got %h required %h", nm, HI, hi); end
        n_cmp++;
        if (LO !== lo) begin n_bad++; $display("FAIL %s_lo: got %h required %h", nm, LO, lo); end
    endtask

    task automatic test_reset;
        #3;
        check_hilo(32'd0, 32'd0, 1'b0, "por");
        @(negedge clk);
        reset_n = 1'b1;
        do_op(MD_MTHI, 32'h55, 32'd0);
        do_op(MD_MTLO, 32'h66, 32'd0);
        @(negedge clk);
        check_hilo(32'h55, 32'h66, 1'b0, "preload");
        do_op(MD_MULT, 32'd3, 32'd3);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_hilo(32'd0, 32'd0, 1'b0, "async_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check_hilo(32'd0, 32'd0, 1'b0, "after_reset");
    endtask

    task automatic test_mult;
        do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        wait_done(0, MULT_N);
        do_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        push_exp(32'h0000_0002, 32'hFFFF_FFFA, "multu");
        wait_done(0, MULT_N);
    endtask

    task automatic test_div;
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        wait_done(0, DIV_N);
        do_op(MD_DIVU, 32'd7, 32'd2);
        push_exp(32'd1, 32'd3, "divu");
        wait_done(0, DIV_N);
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        push_exp(32'd0, 32'h8000_0000, "div_ovf");
        wait_done(0, DIV_N);
    endtask

    task automatic test_div0;
        do_op(MD_MTHI, 32'h11, 32'd0);
        do_op(MD_MTLO, 32'h22, 32'd0);
        do_op(MD_DIV, 32'd100, 32'd0);
        push_exp(32'h11, 32'h22, "div0");
        wait_done(0, DIV_N);
    endtask

    task automatic test_bad_op;
        do_op(3'd6, 32'hDEAD, 32'd1);
        do_op(3'd7, 32'hBEEF, 32'd1);
        @(negedge clk);
        check_hilo(32'h11, 32'h22, 1'b0, "bad_op");
    endtask

    task automatic test_req_and_busy_start;
        int seen;
        @(negedge clk);
        req = 1'b1;
        do_op(MD_MTHI, 32'h1234, 32'd0);
        req = 1'b0;
        @(negedge clk);
        check_hilo(32'h11, 32'h22, 1'b0, "req_suppress");
        do_op(MD_MULT, 32'd6, 32'd7);
        push_exp(32'd0, 32'd42, "mult_busy_start");
        @(negedge clk);
        seen = busy ? 1 : 0;
        // Deliberate protocol violation: start while busy must be dropped.
        start = 1'b1; md_op = MD_MTHI; A = 32'h1234;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(seen, MULT_N);
    endtask

    task automatic test_back_to_back;
        do_op(MD_MULT, 32'd2, 32'd3);
        push_exp(32'd0, 32'd6, "b2b_mult");
        start = 1'b1; md_op = MD_MTLO; A = 32'hABCD; B = 32'd0;
        wait_done(0, MULT_N);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_hilo(32'd0, 32'hABCD, 1'b0, "b2b_mtlo");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div0();
        test_bad_op();
        test_req_and_busy_start();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
